// File: rtl/rca_bist_gen.sv
// rca_bist_gen: built-in self-test sequencer for a 4-slice ripple-carry adder.
// It walks a pattern set onto ta/tb/tcin and waits SETTLE_CYC cycles. It then
// compares the per-slice sum and carry outputs against a golden carry chain.
// Define RCA_BIST_EXHAUSTIVE_EN to run all 512 {tcin,tb,ta} combinations.
// Without it, the sequencer runs a fixed set of 8 directed patterns.
//
// Handshake: start is a single-cycle pulse. It is accepted only in IDLE or DONE.
// Pulses that arrive while a run is in progress are dropped. init is a
// synchronous reset that overrides start and aborts any run in progress.
module rca_bist_gen #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       init,
    input  logic       start,
    output logic [3:0] ta,
    output logic [3:0] tb,
    output logic       tcin,
    input  logic [3:0] dut_sum,
    input  logic [3:0] dut_cout,
    output logic       test,
    output logic [7:0] comp,
    output logic       done,
    output logic       pass,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_APPLY   = 3'd1,
        S_SETTLE  = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

`ifdef RCA_BIST_EXHAUSTIVE_EN
    localparam logic [8:0] LAST_PAT = 9'd511;
`else
    localparam logic [8:0] LAST_PAT = 9'd7;
`endif
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t     state_q;
    logic [8:0] pat_q;
    logic [3:0] settle_q;
    logic       pass_acc_q;
    logic [3:0] ta_q;
    logic [3:0] tb_q;
    logic       tcin_q;
    logic       test_q;
    logic [7:0] comp_q;
    logic       done_q;
    logic       pass_q;

    logic [3:0] gold_s_d;
    logic [3:0] gold_c_d;
    logic       carry_d;
    logic [8:0] pat_inc_d;

    // Pattern index to {tcin, tb, ta} operand word.
    function automatic logic [8:0] pattern_of(input logic [8:0] idx);
`ifdef RCA_BIST_EXHAUSTIVE_EN
        return idx;
`else
        case (idx)
            9'd0:    return 9'h000;  // a=0 b=0 cin=0
            9'd1:    return 9'h10F;  // a=F b=0 cin=1
            9'd2:    return 9'h1F0;  // a=0 b=F cin=1
            9'd3:    return 9'h0FF;  // a=F b=F cin=0
            9'd4:    return 9'h1FF;  // a=F b=F cin=1
            9'd5:    return 9'h0A5;  // a=5 b=A cin=0
            9'd6:    return 9'h15A;  // a=A b=5 cin=1
            9'd7:    return 9'h0F1;  // a=1 b=F cin=0
            default: return 9'h000;
        endcase
`endif
    endfunction

    assign pat_inc_d = pat_q + 9'd1;

    // Golden ripple chain over the operands currently driven to the adder.
    always_comb begin
        carry_d  = tcin_q;
        gold_s_d = '0;
        gold_c_d = '0;
        for (int i = 0; i < 4; i++) begin
            gold_s_d[i] = ta_q[i] ^ tb_q[i] ^ carry_d;
            carry_d     = (ta_q[i] & tb_q[i]) | (ta_q[i] & carry_d) | (tb_q[i] & carry_d);
            gold_c_d[i] = carry_d;
        end
    end

    // Sequencer FSM. All outputs are registered and updated together with state.
    always_ff @(posedge clk) begin
        if (init) begin
            state_q    <= S_IDLE;
            pat_q      <= '0;
            settle_q   <= '0;
            pass_acc_q <= 1'b0;
            ta_q       <= '0;
            tb_q       <= '0;
            tcin_q     <= 1'b0;
            test_q     <= 1'b0;
            comp_q     <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            // A mismatch vector lives for exactly the one COMPARE cycle.
            comp_q <= '0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pat_q                <= '0;
                        pass_acc_q           <= 1'b1;
                        done_q               <= 1'b0;
                        pass_q               <= 1'b0;
                        {tcin_q, tb_q, ta_q} <= pattern_of(9'd0);
                        test_q               <= 1'b1;
                        state_q              <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    settle_q <= '0;
                    state_q  <= S_SETTLE;
                end
                S_SETTLE: begin
                    settle_q <= settle_q + 4'd1;
                    if (settle_q == SETTLE_LAST) begin
                        comp_q  <= {dut_cout ^ gold_c_d, dut_sum ^ gold_s_d};
                        state_q <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (|comp_q) begin
                        pass_acc_q <= 1'b0;
                    end
                    if (pat_q == LAST_PAT) begin
                        // The last pattern's mismatch is folded in directly.
                        pass_q  <= pass_acc_q & ~(|comp_q);
                        done_q  <= 1'b1;
                        test_q  <= 1'b0;
                        ta_q    <= '0;
                        tb_q    <= '0;
                        tcin_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        pat_q                <= pat_inc_d;
                        {tcin_q, tb_q, ta_q} <= pattern_of(pat_inc_d);
                        state_q              <= S_APPLY;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ta          = ta_q;
    assign tb          = tb_q;
    assign tcin        = tcin_q;
    assign test        = test_q;
    assign comp        = comp_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rca_bist_gen.sv
// Testbench for rca_bist_gen. It drives two instances that share clk, init and
// start, using settle lengths 1 and 3. Each instance is connected to its own
// adder, and each adder can have stuck-at faults injected. A cycle-by-cycle
// model predicts every output from the pattern list, the run timing and the
// arithmetic sum a+b+cin.
module tb_rca_bist_gen;
  localparam int S0 = 1;
  localparam int S1 = 3;
`ifdef RCA_BIST_EXHAUSTIVE_EN
  localparam int NPAT = 512;
`else
  localparam int NPAT = 8;
`endif

  typedef struct packed {
    logic       test;
    logic [3:0] ta;
    logic [3:0] tb;
    logic       tcin;
    logic [7:0] comp;
    logic       done;
    logic       pass;
  } obs_t;

  logic clk = 1'b0;
  logic init = 1'b1;
  logic start = 1'b0;

  logic [3:0] ta0, tb0, sum0, cout0, ta1, tb1, sum1, cout1;
  logic       tcin0, test0, done0, pass0, tcin1, test1, done1, pass1;
  logic [7:0] comp0, comp1;
  logic [2:0] dbg0, dbg1;

  // Fault masks per instance; the bit layout matches comp: {cout[3:0], sum[3:0]}.
  logic [7:0] sa0_m[2];
  logic [7:0] sa1_m[2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Adder reference from plain addition: carry out of slice i is bit i+1 of
  // the sum of the low i+1 operand bits plus carry-in.
  function automatic logic [7:0] gold8(input logic [3:0] a, input logic [3:0] b, input logic c);
    int s;
    int m;
    logic [3:0] co;
    s = int'(a) + int'(b) + int'(c);
    for (int i = 0; i < 4; i++) begin
      m = (2 << i) - 1;
      co[i] = (((int'(a) & m) + (int'(b) & m) + int'(c)) >> (i + 1)) & 1;
    end
    return {co, s[3:0]};
  endfunction

  assign {cout0, sum0} = (gold8(ta0, tb0, tcin0) & ~sa0_m[0]) | sa1_m[0];
  assign {cout1, sum1} = (gold8(ta1, tb1, tcin1) & ~sa0_m[1]) | sa1_m[1];

  rca_bist_gen #(.SETTLE_CYC(S0)) u_dut0 (
    .clk(clk), .init(init), .start(start), .ta(ta0), .tb(tb0), .tcin(tcin0),
    .dut_sum(sum0), .dut_cout(cout0), .test(test0), .comp(comp0),
    .done(done0), .pass(pass0), .dbg_state_o(dbg0)
  );

  rca_bist_gen #(.SETTLE_CYC(S1)) u_dut1 (
    .clk(clk), .init(init), .start(start), .ta(ta1), .tb(tb1), .tcin(tcin1),
    .dut_sum(sum1), .dut_cout(cout1), .test(test1), .comp(comp1),
    .done(done1), .pass(pass1), .dbg_state_o(dbg1)
  );

  function automatic int settle_of(input int g);
    return (g == 0) ? S0 : S1;
  endfunction

  function automatic obs_t obs_of(input int g);
    obs_t o;
    if (g == 0) o = {test0, ta0, tb0, tcin0, comp0, done0, pass0};
    else        o = {test1, ta1, tb1, tcin1, comp1, done1, pass1};
    return o;
  endfunction

  // Pattern p as {tcin, tb, ta}.
  function automatic logic [8:0] pat(input int p);
`ifdef RCA_BIST_EXHAUSTIVE_EN
    return p[8:0];
`else
    case (p)
      0: return 9'h000;
      1: return 9'h10F;
      2: return 9'h1F0;
      3: return 9'h0FF;
      4: return 9'h1FF;
      5: return 9'h0A5;
      6: return 9'h15A;
      7: return 9'h0F1;
      default: return 9'h000;
    endcase
`endif
  endfunction

  // Bits in which the faulty adder differs from the arithmetic result.
  function automatic logic [7:0] fault_diff(input int g, input logic [8:0] pv);
    logic [7:0] gv;
    gv = gold8(pv[3:0], pv[7:4], pv[8]);
    return ((gv & ~sa0_m[g]) | sa1_m[g]) ^ gv;
  endfunction

  // Issues one start pulse, then checks every output of both instances on each
  // cycle until the slower instance has been in DONE for gap+1 cycles. The
  // run can optionally pulse start at cycle pulse_k. It can also assert init
  // at cycle init_k, which aborts the run.
  task automatic run_and_check(input string name, input int pulse_k, input int init_k, input int gap);
    bit   exp_pass[2];
    int   kmax;
    int   s;
    int   len;
    int   p;
    int   ph;
    logic [8:0] pv;
    obs_t e;
    obs_t o;
    for (int g = 0; g < 2; g++) begin
      exp_pass[g] = 1'b1;
      for (int q = 0; q < NPAT; q++)
        if (fault_diff(g, pat(q)) != 8'h00) exp_pass[g] = 1'b0;
    end
    kmax = NPAT * (S1 + 2) + 1 + gap;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (init_k > 0 && k == init_k + 1) begin
        init = 1'b0;
        for (int g = 0; g < 2; g++) begin
          o = obs_of(g);
          n_chk++;
          if (o !== 20'h0) begin
            n_err++;
            $display("FAIL %s_abort inst%0d: got %h expected %h", name, g, o, 20'h0);
          end
        end
        return;
      end
      for (int g = 0; g < 2; g++) begin
        s = settle_of(g);
        len = NPAT * (s + 2);
        e = '0;
        if (k <= len) begin
          p = (k - 1) / (s + 2);
          ph = (k - 1) % (s + 2);
          pv = pat(p);
          e.test = 1'b1;
          e.ta = pv[3:0];
          e.tb = pv[7:4];
          e.tcin = pv[8];
          e.comp = (ph == s + 1) ? fault_diff(g, pv) : 8'h00;
        end else begin
          e.done = 1'b1;
          e.pass = exp_pass[g];
        end
        o = obs_of(g);
        if (!e.done) o.pass = 1'b0;
        n_chk++;
        if (o !== e) begin
          n_err++;
          $display("FAIL %s inst%0d k=%0d: got test=%b ta=%h tb=%h cin=%b comp=%h done=%b pass=%b expected test=%b ta=%h tb=%h cin=%b comp=%h done=%b pass=%b",
                   name, g, k, o.test, o.ta, o.tb, o.tcin, o.comp, o.done, o.pass,
                   e.test, e.ta, e.tb, e.tcin, e.comp, e.done, e.pass);
        end
      end
      if (k == pulse_k) start = 1'b1;
      if (k == init_k) init = 1'b1;
    end
  endtask

  task automatic clear_faults();
    for (int g = 0; g < 2; g++) begin
      sa0_m[g] = 8'h00;
      sa1_m[g] = 8'h00;
    end
  endtask

  task automatic test_reset();
    obs_t o;
    init = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      o = obs_of(g);
      n_chk++;
      if (o !== 20'h0) begin
        n_err++;
        $display("FAIL reset inst%0d: got %h expected %h", g, o, 20'h0);
      end
    end
    init = 1'b0;
    start = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      o = obs_of(g);
      n_chk++;
      if (o !== 20'h0) begin
        n_err++;
        $display("FAIL idle inst%0d: got %h expected %h", g, o, 20'h0);
      end
    end
  endtask

  task automatic test_golden();
    clear_faults();
    run_and_check("golden", 0, 0, 1);
  endtask

  task automatic test_stuck_faults();
    clear_faults();
    sa0_m[0] = 8'h04;  // sum[2] stuck at 0
    sa1_m[1] = 8'h80;  // cout[3] stuck at 1
    run_and_check("stuck_a", 0, 0, 0);
    clear_faults();
    sa1_m[0] = 8'h80;
    sa0_m[1] = 8'h04;
    run_and_check("stuck_b", 0, 0, 0);
  endtask

  task automatic test_random_faults();
    for (int r = 0; r < 6; r++) begin
      for (int g = 0; g < 2; g++) begin
        sa0_m[g] = 8'($urandom) & 8'($urandom) & 8'($urandom);
        sa1_m[g] = 8'($urandom) & 8'($urandom) & 8'($urandom);
        if ($urandom_range(0, 2) == 0) begin
          sa0_m[g] = 8'h00;
          sa1_m[g] = 8'h00;
        end
      end
      run_and_check("random", 0, 0, $urandom_range(0, 3));
    end
  endtask

  task automatic test_midrun_start();
    clear_faults();
    run_and_check("midrun_start", $urandom_range(2, 20), 0, 0);
  endtask

  task automatic test_init_abort();
    clear_faults();
    sa1_m[0] = 8'h01;
    run_and_check("init_abort", 0, 10, 0);
    clear_faults();
    run_and_check("after_abort", 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    clear_faults();
    sa0_m[1] = 8'h10;
    run_and_check("b2b_first", 0, 0, 0);
    clear_faults();
    run_and_check("b2b_second", 0, 0, 0);
  endtask

  initial begin
    clear_faults();
    test_reset();
    test_golden();
    test_stuck_faults();
    test_random_faults();
    test_midrun_start();
    test_init_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
